rol32_seq: RTL and testbench

ROL32_SEQ -- requirements
Module: rol32_seq

---
 rtl/rol32_seq.sv | 83 ++++++++
 tb/tb_rol32_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rol32_seq.sv
// Sequential 32-bit rotate-left: the operand is rotated one bit per clock
// until the captured 5-bit amount is exhausted, then the result is published.
module rol32_seq (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [31:0] num_rotate,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    state_t      state_q;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic [31:0] out_q;
    logic [4:0]  count_q;
    logic        busy_q;
    logic        done_q;

    // Only the low five bits of the amount matter (rotation is modulo 32).
    logic unused_ok;
    assign unused_ok = ^num_rotate[31:5];

    assign data_d = {data_q[30:0], data_q[31]};

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            data_q  <= 32'h0;
            out_q   <= 32'h0;
            count_q <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        data_q  <= in;
                        count_q <= num_rotate[4:0];
                        busy_q  <= 1'b1;
                        state_q <= ROT;
                    end
                end
                ROT: begin
                    if (count_q != 5'd0) begin
                        data_q  <= data_d;
                        count_q <= count_q - 5'd1;
                    end else begin
                        out_q   <= data_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_rol32_seq.sv
// Randomized scoreboard bench for rol32_seq: the driver queues expected
// results from a plain-arithmetic rotate model, a monitor checks each done.
module tb_rol32_seq;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] in;
    logic [31:0] num_rotate;
    logic [31:0] out;
    logic        busy;
    logic        done;

    rol32_seq dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .in         (in),
        .num_rotate (num_rotate),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [31:0] result;
        int          doneCycle;
    } expect_t;

    expect_t     expQ[$];
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    logic        prevDone = 1'b0;
    logic [31:0] prevOut  = 32'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [31:0] rotModel(input logic [31:0] x, input logic [31:0] amt);
        logic [63:0] both;
        int          n;
        n    = amt % 32;
        both = {x, x} << n;
        return both[63:32];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!clear) begin
            if (busy) checkOutput("outStableDuringRot", out, prevOut);
            if (done) begin
                checkOutput("doneSingleCycle", {31'h0, prevDone}, 32'h0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'h1, 32'h0);
                end else begin
                    expect_t e;
                    e = expQ.pop_front();
                    checkOutput("result", out, e.result);
                    checkOutput("latency", cycle, e.doneCycle);
                end
            end
        end
        prevDone = done;
        prevOut  = out;
    end

    task automatic waitDone(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!done && k < 45);
        if (!done) checkOutput({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    // Issues one start; optionally pulses a second start while busy and/or
    // holds start high during the done cycle, both of which must be dropped.
    task automatic applyStimulus(input logic [31:0] inVal, input logic [31:0] amt,
                                 input int injectAt, input bit startInDone);
        expect_t e;
        @(negedge clock);
        start      = 1'b1;
        in         = inVal;
        num_rotate = amt;
        e.result    = rotModel(inVal, amt);
        e.doneCycle = cycle + int'(amt % 32) + 2;
        expQ.push_back(e);
        @(negedge clock);
        start      = 1'b0;
        in         = $urandom;
        num_rotate = $urandom;
        checkOutput("busyAfterStart", {31'h0, busy}, 32'h1);
        if (injectAt > 0) begin
            repeat (injectAt - 1) @(negedge clock);
            start      = 1'b1;
            in         = 32'hFFFF_FFFF;
            num_rotate = 32'd3;
            @(negedge clock);
            start = 1'b0;
        end
        waitDone("op");
        if (startInDone) begin
            start      = 1'b1;
            in         = $urandom;
            num_rotate = $urandom;
        end
    endtask

    initial begin
        clear      = 1'b1;
        start      = 1'b1;
        in         = 32'hA5A5_A5A5;
        num_rotate = 32'd7;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("resetOut", out, 32'h0);
        checkOutput("resetBusy", {31'h0, busy}, 32'h0);
        checkOutput("resetDone", {31'h0, done}, 32'h0);
        clear = 1'b0;
        start = 1'b0;

        applyStimulus(32'h8000_0001, 32'd1, 0, 1'b0);
        applyStimulus(32'h1234_5678, 32'd36, 0, 1'b1);
        applyStimulus(32'hDEAD_BEEF, 32'd32, 0, 1'b0);
        applyStimulus(32'h0000_0001, 32'd31, 0, 1'b0);
        applyStimulus(32'h0000_000F, 32'd8, 3, 1'b0);

        // Abort mid-rotation: no done may follow, out returns to zero.
        applyStimulus(32'h0000_0003, 32'd0, 0, 1'b0);
        @(negedge clock);
        start      = 1'b1;
        in         = 32'h0000_FFFF;
        num_rotate = 32'd20;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        checkOutput("clearOut", out, 32'h0);
        checkOutput("clearBusy", {31'h0, busy}, 32'h0);
        repeat (30) @(negedge clock);
        applyStimulus(32'h0000_FFFF, 32'd16, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            applyStimulus($urandom, $urandom, (i % 5 == 0) ? 2 : 0, (i % 3 == 0));
        end

        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("queueDrained", expQ.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
